// File: rtl/cpu_pkg.sv
// ============================================================
// cpu_pkg : shared CPU types and constants
// rev 1.0
// ============================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_PEND = 2'd2
  } pcg_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_gen_if.sv
// ============================================================
// pc_fetch_gen_if : redirect inputs and fetch request handshake
// rev 1.0
// ============================================================
`default_nettype none

interface pc_fetch_gen_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_REDIR = 4
);

  logic [NUM_REDIR-1:0]       redir_valid;
  logic [NUM_REDIR*WIDTH-1:0] redir_pc;
  logic                       req_valid;
  logic                       req_ready;
  logic [WIDTH-1:0]           req_pc;
  logic                       req_adel;
  logic                       wrong_path;
  logic                       redir_taken;

  // master = PC generator, slave = pipeline/bridge side
  modport master (
    input  redir_valid, redir_pc, req_ready,
    output req_valid, req_pc, req_adel, wrong_path, redir_taken
  );

  modport slave (
    output redir_valid, redir_pc, req_ready,
    input  req_valid, req_pc, req_adel, wrong_path, redir_taken
  );

endinterface

`default_nettype wire

// File: rtl/pc_redir_arb.sv
// ============================================================
// pc_redir_arb : fixed-priority redirect select, index 0 wins
// rev 1.0
// ============================================================
`default_nettype none

module pc_redir_arb #(
  parameter int WIDTH     = 32,
  parameter int NUM_REDIR = 4
) (
  input  logic [NUM_REDIR-1:0]       valid,
  input  logic [NUM_REDIR*WIDTH-1:0] pc,
  output logic [WIDTH-1:0]           tgt,
  output logic                       any
);

  logic [NUM_REDIR-1:0] onehot;
  logic [WIDTH-1:0]     masked [NUM_REDIR];

  // isolate the lowest set bit
  assign onehot = valid & (~valid + NUM_REDIR'(1));
  assign any    = |valid;

  generate
    for (genvar i = 0; i < NUM_REDIR; i++) begin : g_mask
      assign masked[i] = pc[i*WIDTH +: WIDTH] & {WIDTH{onehot[i]}};
    end
  endgenerate

  always_comb begin
    tgt = '0;
    for (int i = 0; i < NUM_REDIR; i++) begin
      tgt = tgt | masked[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_gen.sv
// ============================================================
// pc_fetch_gen : IF-stage next-PC generator with redirect hold
// rev 1.0
// ============================================================
`default_nettype none

module pc_fetch_gen
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NUM_REDIR   = 4,
  parameter int               FETCH_BYTES = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_VECTOR)
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_fetch_gen_if.master bus
);

  pcg_state_t       state, state_n;
  logic [WIDTH-1:0] cur_pc, cur_pc_n;
  logic [WIDTH-1:0] pend_pc, pend_pc_n;
  logic [WIDTH-1:0] tgt;
  logic             any;
  logic             fire;

  pc_redir_arb #(
    .WIDTH     (WIDTH),
    .NUM_REDIR (NUM_REDIR)
  ) u_arb (
    .valid (bus.redir_valid),
    .pc    (bus.redir_pc),
    .tgt   (tgt),
    .any   (any)
  );

  assign fire = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PCG_BOOT;
      cur_pc  <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      cur_pc  <= cur_pc_n;
      pend_pc <= pend_pc_n;
    end
  end

  // req_pc is cur_pc in every state, so a stalled request never changes under the bridge
  always_comb begin
    state_n   = state;
    cur_pc_n  = cur_pc;
    pend_pc_n = pend_pc;
    case (state)
      PCG_BOOT: begin
        state_n = PCG_RUN;
        if (any) cur_pc_n = tgt;
      end
      PCG_RUN: begin
        if (any && fire) begin
          cur_pc_n = tgt;
        end else if (any) begin
          pend_pc_n = tgt;
          state_n   = PCG_PEND;
        end else if (fire) begin
          cur_pc_n = cur_pc + WIDTH'(FETCH_BYTES);
        end
      end
      PCG_PEND: begin
        if (fire) begin
          cur_pc_n = any ? tgt : pend_pc;
          state_n  = PCG_RUN;
        end else if (any) begin
          pend_pc_n = tgt;
        end
      end
      default: state_n = PCG_BOOT;
    endcase
  end

  assign bus.req_valid   = (state != PCG_BOOT);
  assign bus.req_pc      = cur_pc;
  assign bus.req_adel    = |cur_pc[1:0];
  assign bus.wrong_path  = fire & (any | (state == PCG_PEND));
  assign bus.redir_taken = any & rst_n;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
// Scoreboard bench for pc_fetch_gen: randomized + directed redirects against a behavioural model.
`default_nettype none

module tb_pc_fetch_gen;

  localparam int          W     = 32;
  localparam int          NR    = 4;
  localparam logic [31:0] RST_V = 32'hbfc00000;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          adel;
    bit          wp;
    bit          taken;
    bit          chk_pc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  exp_t q[$];

  // behavioural model state
  bit          m_boot;
  bit          m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;

  pc_fetch_gen_if #(.WIDTH(W), .NUM_REDIR(NR)) bus ();

  pc_fetch_gen #(
    .WIDTH       (W),
    .NUM_REDIR   (NR),
    .FETCH_BYTES (4),
    .RESET_PC    (RST_V)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input logic [31:0] c3, input logic [31:0] c2,
                                         input logic [31:0] c1, input logic [31:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'hfffffffc - 32'($urandom_range(0, 2) * 4);
      1:       v = $urandom;
      default: v = $urandom & 32'hfffffffc;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle of stimulus; expectation for this cycle is pushed, then the model steps
  task automatic drive(input bit rst, input logic [3:0] rv, input logic [127:0] rp, input bit rdy);
    exp_t        e;
    logic [31:0] tgt;
    bit          fire;
    @(negedge clk);
    rst_n           = !rst;
    bus.redir_valid = rv;
    bus.redir_pc    = rp;
    bus.req_ready   = rdy;
    if (rst) begin
      m_boot = 1'b1;
      m_pend = 1'b0;
      m_pc   = RST_V;
      e = '{valid: 1'b0, pc: RST_V, adel: 1'b0, wp: 1'b0, taken: 1'b0, chk_pc: 1'b1};
      q.push_back(e);
    end else begin
      tgt = '0;
      for (int i = NR - 1; i >= 0; i--) begin
        if (rv[i]) tgt = rp[i*32 +: 32];
      end
      fire = !m_boot && rdy;
      e = '{valid: !m_boot, pc: m_pc, adel: (m_pc[1:0] != 2'b00),
            wp: fire && ((rv != 4'b0) || m_pend), taken: (rv != 4'b0), chk_pc: !m_boot};
      q.push_back(e);
      if (m_boot) begin
        m_boot = 1'b0;
        if (rv != 4'b0) m_pc = tgt;
      end else if (fire) begin
        if (rv != 4'b0)  m_pc = tgt;
        else if (m_pend) m_pc = m_pend_pc;
        else             m_pc = m_pc + 32'd4;
        m_pend = 1'b0;
      end else if (rv != 4'b0) begin
        m_pend    = 1'b1;
        m_pend_pc = tgt;
      end
    end
  endtask

  // monitor: compares whatever the DUT presents against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("req_valid", 32'(bus.req_valid), 32'(e.valid));
        check("wrong_path", 32'(bus.wrong_path), 32'(e.wp));
        check("redir_taken", 32'(bus.redir_taken), 32'(e.taken));
        if (e.chk_pc) begin
          check("req_pc", bus.req_pc, e.pc);
          check("req_adel", 32'(bus.req_adel), 32'(e.adel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rv;
    tests           = 0;
    failed          = 0;
    rst_n           = 1'b1;
    bus.redir_valid = '0;
    bus.redir_pc    = '0;
    bus.req_ready   = 1'b0;
    #1 rst_n = 1'b0;

    drive(1, 4'b0, '0, 1);
    drive(0, 4'b0, '0, 1);                                              // BOOT
    drive(0, 4'b0, '0, 1);                                              // bfc00000
    drive(0, 4'b0, '0, 1);                                              // bfc00004
    drive(0, 4'b0100, pack4(0, 32'h2000, 0, 0), 0);                     // stall + redirect
    drive(0, 4'b0, '0, 0);
    drive(0, 4'b0, '0, 0);
    drive(0, 4'b0, '0, 1);                                              // fire, wrong path
    drive(0, 4'b1010, pack4(32'h1000, 0, 32'h80000180, 0), 1);          // ch1 beats ch3
    drive(0, 4'b0100, pack4(0, 32'h2000, 0, 0), 0);
    drive(0, 4'b0001, pack4(0, 0, 0, 32'hbfc00380), 0);                 // overwrite pending
    drive(0, 4'b0, '0, 1);
    drive(0, 4'b1000, pack4(32'h2, 0, 0, 0), 1);
    drive(0, 4'b0, '0, 1);                                              // misaligned 0x2
    drive(0, 4'b0001, pack4(0, 0, 0, 32'hfffffffc), 1);                 // 0x6, redirect to wrap
    drive(0, 4'b0, '0, 1);                                              // fffffffc fires
    drive(0, 4'b0010, pack4(0, 0, 32'h1234, 0), 0);                     // at 0, enter PEND
    drive(1, 4'b0, '0, 0);                                              // reset mid-PEND
    drive(0, 4'b0, '0, 1);
    drive(0, 4'b0, '0, 1);
    drive(0, 4'b0, '0, 1);

    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      drive(($urandom_range(0, 59) == 0), rv,
            pack4(rand_pc(), rand_pc(), rand_pc(), rand_pc()),
            ($urandom_range(0, 2) != 0));
    end
    drive(0, 4'b0, '0, 0);

    @(negedge clk);
    #3;
    check("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
